vmicro16_alu_arbiter: RTL and testbench
=======================================

// Module: vmicro16_alu_arbiter
// PURPOSE
//  Shares one combinational vmicro16_alu between CORES requesters (per-core execute units or
//  peripherals) using round-robin arbitration and a req/ack handshake. Latches the winner's
//  op/a/b/flags, drives the shared ALU, registers the result, and returns it with a one-cycle ack.
//  Sits between the cores' execute stages and the single ALU instance in the SoC top.
// PARAMETERS
//  CORES   2   number of requesters (>=1)
//  DATA_W  16  operand/result width
//  OP_W    5   ALU opcode width (matches VMICRO16_ALU_* encodings)
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             synchronous, active-high reset
//  req        in   CORES         per-core request; hold until ack
//  op_in      in   CORES*OP_W    per-core ALU op, core i at [i*OP_W +: OP_W]
//  a_in       in   CORES*DATA_W  per-core operand a
//  b_in       in   CORES*DATA_W  per-core operand b
//  flags_in   in   CORES*4       per-core NZCV flags (N=bit3, V=bit0)
//  ack        out  CORES         one-hot, one-cycle completion pulse
//  res_out    out  DATA_W        result; valid only while ack != 0
//  alu_op     out  OP_W          to ALU .op
//  alu_a      out  DATA_W        to ALU .a
//  alu_b      out  DATA_W        to ALU .b
//  alu_flags  out  4             to ALU .flags
//  alu_c      in   DATA_W        from ALU .c (combinational)
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, grant=0, ack=0, res_out=0, alu_op/a/b/flags=0.
//  FSM: IDLE -> EXEC -> RESP -> IDLE; exactly one transaction in flight.
//  IDLE: if req!=0, winner = first set req bit scanning rr_ptr, rr_ptr+1, ... mod CORES.
//   At the edge: latch winner's op/a/b/flags into alu_* regs, grant<=winner, go EXEC.
//   If req==0, stay IDLE; alu_* regs hold their last values.
//  EXEC: alu_* stable from latches; at the edge res_out<=alu_c, ack[grant]<=1, go RESP.
//  RESP: ack[grant]=1 for this cycle only; at the edge ack<=0, rr_ptr<=(grant+1) mod CORES,
//   go IDLE. req is not sampled in EXEC/RESP.
//  Latency: req seen at edge E0 -> ack high in the cycle after E1 (between E1 and E2).
//   Peak throughput: one op per 3 cycles.
//  Requester drops req in the cycle after its ack. A req still high in IDLE is a new request.
//  Operands are captured at grant. Changes to a_in/b_in/op_in after grant do not affect
//   the result.
//  req dropped after grant: the op completes and ack still pulses; the requester ignores it.
//  Fairness: a continuously requesting core waits at most CORES-1 transactions.
//  Simultaneous reqs: rr_ptr decides. After reset, core 0 has priority.
//  Reset mid-transaction: abandoned, no ack issued, all state to reset values next cycle.
//  CORES=1: rr_ptr is constant 0; FSM timing unchanged.
//  res_out holds its value after ack falls, but is only defined while ack is high.
// TESTING (wrap a real vmicro16_alu; rassert on every check)
//  1 Reset: reset=1 for 2 clks with req=2'b11 -> ack=0, res_out=0, alu_*=0 throughout.
//  2 Single op: core0 SETC, b={8'h00,BR_U}, flags=0 -> ack=2'b01 exactly 2 edges after the
//    req edge, res_out=16'h0001.
//  3 Condition: core1 SETC BR_E with flags=4'b0100 -> ack=2'b10, res_out=1.
//    Same op with flags=0 -> res_out=0.
//  4 Contention: both req from reset, core0 BR_G flags=0, core1 BR_G flags=4'b0100 ->
//    core0 acked first (res 1), core1 next (res 0). Core1 re-reqs while core0 holds req ->
//    core1 is granted before core0's second request (round-robin alternation).
//  5 Operand capture: change core0 b_in in the EXEC cycle -> result reflects the latched b.
//  6 Reset mid-op: assert reset during EXEC -> no ack, IDLE next cycle; a new req completes
//    normally.

Source files
------------

// File: rtl/vmicro16_alu_arbiter.sv
// -----------------------------------------------------------------------------
// vmicro16_alu_arbiter
//
// Lets CORES requesters share one combinational vmicro16_alu. Each transaction
// runs IDLE -> EXEC -> RESP, so only one is ever in flight. In IDLE a
// round-robin scan picks a winner starting at rr_ptr. The winner's
// op/a/b/flags are latched onto the alu_* outputs. In EXEC the ALU result is
// registered and the winner's ack bit is set. In RESP ack is high for exactly
// one cycle and rr_ptr moves past the winner.
//
// Ports
//   clk, reset  rising-edge clock, synchronous active-high reset
//   req         per-core request, held by the requester until its ack
//   op_in       per-core ALU opcode, core i at [i*OP_W +: OP_W]
//   a_in, b_in  per-core operands, core i at [i*DATA_W +: DATA_W]
//   flags_in    per-core NZCV flags, core i at [i*4 +: 4] (N=bit3, V=bit0)
//   ack         one-hot, one-cycle completion pulse
//   res_out     registered ALU result, defined while ack != 0
//   alu_op/a/b/flags  latched operands driven to the shared ALU
//   alu_c       combinational result returned by the shared ALU
// -----------------------------------------------------------------------------
module vmicro16_alu_arbiter #(
    parameter int CORES  = 2,
    parameter int DATA_W = 16,
    parameter int OP_W   = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CORES-1:0]          req,
    input  logic [CORES*OP_W-1:0]     op_in,
    input  logic [CORES*DATA_W-1:0]   a_in,
    input  logic [CORES*DATA_W-1:0]   b_in,
    input  logic [CORES*4-1:0]        flags_in,
    output logic [CORES-1:0]          ack,
    output logic [DATA_W-1:0]         res_out,
    output logic [OP_W-1:0]           alu_op,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [3:0]                alu_flags,
    input  logic [DATA_W-1:0]         alu_c
);

    // A single core still gets a 1-bit pointer; it simply never leaves 0.
    localparam int              PTR_W     = (CORES > 1) ? $clog2(CORES) : 1;
    localparam logic [PTR_W:0]  CORES_X   = (PTR_W + 1)'(CORES);
    localparam logic [PTR_W-1:0] LAST_CORE = PTR_W'(CORES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    grant_q, grant_d;
    logic [CORES-1:0]    ack_q, ack_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [3:0]          alu_flags_q, alu_flags_d;

    logic                found_s;
    logic [PTR_W-1:0]    winner_s;
    logic [PTR_W:0]      cand_s;
    logic [PTR_W-1:0]    cand_lo_s;
    logic [OP_W-1:0]     sel_op_s;
    logic [DATA_W-1:0]   sel_a_s;
    logic [DATA_W-1:0]   sel_b_s;
    logic [3:0]          sel_flags_s;

    // Round-robin scan. The loop runs from the farthest offset down to offset
    // 0, so the last hit written is the one nearest rr_ptr.
    always_comb begin
        found_s   = 1'b0;
        winner_s  = '0;
        cand_s    = '0;
        cand_lo_s = '0;
        for (int k = CORES - 1; k >= 0; k--) begin
            cand_s    = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
            cand_s    = (cand_s >= CORES_X) ? (cand_s - CORES_X) : cand_s;
            cand_lo_s = cand_s[PTR_W-1:0];
            winner_s  = req[cand_lo_s] ? cand_lo_s : winner_s;
            found_s   = found_s | req[cand_lo_s];
        end
    end

    // Operand mux selecting the winner's fields.
    always_comb begin
        sel_op_s    = '0;
        sel_a_s     = '0;
        sel_b_s     = '0;
        sel_flags_s = 4'h0;
        for (int i = 0; i < CORES; i++) begin
            sel_op_s    = (winner_s == PTR_W'(i)) ? op_in[i*OP_W +: OP_W]       : sel_op_s;
            sel_a_s     = (winner_s == PTR_W'(i)) ? a_in[i*DATA_W +: DATA_W]    : sel_a_s;
            sel_b_s     = (winner_s == PTR_W'(i)) ? b_in[i*DATA_W +: DATA_W]    : sel_b_s;
            sel_flags_s = (winner_s == PTR_W'(i)) ? flags_in[i*4 +: 4]          : sel_flags_s;
        end
    end

    // Transaction FSM next-state logic. ack defaults low, so it can only pulse
    // for the single cycle spent in RESP.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        ack_d       = '0;
        res_d       = res_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_flags_d = alu_flags_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    alu_op_d    = sel_op_s;
                    alu_a_d     = sel_a_s;
                    alu_b_d     = sel_b_s;
                    alu_flags_d = sel_flags_s;
                    grant_d     = winner_s;
                    state_d     = ST_EXEC;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_EXEC: begin
                res_d = alu_c;
                for (int i = 0; i < CORES; i++) begin
                    ack_d[i] = (grant_q == PTR_W'(i));
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rr_ptr_d = (grant_q == LAST_CORE) ? '0 : (grant_q + PTR_W'(1));
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset. A reset during a transaction
    // abandons it, and no ack is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            res_q       <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_flags_q <= 4'h0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            res_q       <= res_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_flags_q <= alu_flags_d;
        end
    end

    assign ack       = ack_q;
    assign res_out   = res_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_flags = alu_flags_q;

endmodule

// File: tb/tb_vmicro16_alu_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for vmicro16_alu_arbiter with two cores. The bench models
// a small ALU and feeds alu_c from the DUT's alu_* outputs. Opcode and
// condition encodings are local to this bench. Each expected ack/result is
// computed from the driven stimulus and queued at issue time. It is popped
// when the DUT acks.
// -----------------------------------------------------------------------------
module tb_vmicro16_alu_arbiter;

    localparam int CORES = 2;
    localparam int DW    = 16;
    localparam int OW    = 5;

    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_XOR  = 5'h05;
    localparam logic [4:0] OP_SETC = 5'h0E;
    localparam logic [7:0] BR_U    = 8'h00;
    localparam logic [7:0] BR_E    = 8'h01;
    localparam logic [7:0] BR_NE   = 8'h02;
    localparam logic [7:0] BR_G    = 8'h03;

    logic                  clk   = 1'b0;
    logic                  reset = 1'b1;
    logic [CORES-1:0]      req   = '0;
    logic [CORES*OW-1:0]   op_in = '0;
    logic [CORES*DW-1:0]   a_in  = '0;
    logic [CORES*DW-1:0]   b_in  = '0;
    logic [CORES*4-1:0]    flags_in = '0;
    logic [CORES-1:0]      ack;
    logic [DW-1:0]         res_out;
    logic [OW-1:0]         alu_op;
    logic [DW-1:0]         alu_a;
    logic [DW-1:0]         alu_b;
    logic [3:0]            alu_flags;
    logic [DW-1:0]         alu_c;

    typedef struct packed {
        logic [1:0]  ack;
        logic [15:0] res;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    vmicro16_alu_arbiter #(.CORES(CORES), .DATA_W(DW), .OP_W(OW)) dut (
        .clk(clk), .reset(reset), .req(req), .op_in(op_in), .a_in(a_in),
        .b_in(b_in), .flags_in(flags_in), .ack(ack), .res_out(res_out),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_flags(alu_flags),
        .alu_c(alu_c)
    );

    function automatic logic cond_fn(input logic [7:0] br, input logic [3:0] f);
        case (br)
            BR_U:    return 1'b1;
            BR_E:    return f[2];
            BR_NE:   return !f[2];
            BR_G:    return !f[2] && (f[3] == f[0]);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] alu_fn(input logic [4:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] f);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_XOR:  return a ^ b;
            OP_SETC: return {15'b0, cond_fn(b[7:0], f)};
            default: return 16'h0000;
        endcase
    endfunction

    // Stand-in for the shared combinational ALU.
    always_comb alu_c = alu_fn(alu_op, alu_a, alu_b, alu_flags);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int c, input logic [4:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] f);
        exp_t       e;
        logic [1:0] one;
        one = 2'b01;
        op_in[c*OW +: OW]    = op;
        a_in[c*DW +: DW]     = a;
        b_in[c*DW +: DW]     = b;
        flags_in[c*4 +: 4]   = f;
        req[c]               = 1'b1;
        e.ack = one << c;
        e.res = alu_fn(op, a, b, f);
        sb.push_back(e);
    endtask

    // Advance until ack rises or the budget runs out; a timeout leaves ack at 0.
    task automatic wait_ack(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (ack == '0 && cyc < max_cyc);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        req      = 2'b11;
        op_in    = {OP_SUB, OP_ADD};
        a_in     = 32'h1234_5678;
        b_in     = 32'h9ABC_DEF0;
        flags_in = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b expected 00", ack); end
            n_checks++; if (res_out !== 16'h0000) begin n_fail++; $display("FAIL reset_res: got %h expected 0000", res_out); end
            n_checks++; if ({alu_op, alu_a, alu_b, alu_flags} !== 41'h0) begin
                n_fail++; $display("FAIL reset_alu: got op=%h a=%h b=%h f=%h expected all 0", alu_op, alu_a, alu_b, alu_flags);
            end
        end
        reset = 1'b0;
        req   = 2'b00;
        tick();
        n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL reset_idle_ack: got %b expected 00", ack); end
    endtask

    task automatic test_single_op();
        exp_t e;
        int   cyc;
        issue(0, OP_SETC, 16'h5A5A, {8'h00, BR_U}, 4'h0);
        tick();
        n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL single_exec_ack: got %b expected 00", ack); end
        n_checks++; if (alu_op !== OP_SETC) begin n_fail++; $display("FAIL single_alu_op: got %h expected %h", alu_op, OP_SETC); end
        n_checks++; if (alu_a !== 16'h5A5A) begin n_fail++; $display("FAIL single_alu_a: got %h expected 5a5a", alu_a); end
        wait_ack(4, cyc);
        e = sb.pop_front();
        n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL single_latency: got %0d expected 1 more edge", cyc); end
        n_checks++; if (ack !== e.ack) begin n_fail++; $display("FAIL single_ack: got %b expected %b", ack, e.ack); end
        n_checks++; if (res_out !== 16'h0001) begin n_fail++; $display("FAIL single_res: got %h expected 0001", res_out); end
        req[0] = 1'b0;
        tick();
        n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL single_ack_pulse: got %b expected 00", ack); end
    endtask

    task automatic test_condition();
        exp_t       e;
        int         cyc;
        logic [3:0] fl[2];
        fl[0] = 4'b0100;
        fl[1] = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            issue(1, OP_SETC, 16'h0000, {8'h00, BR_E}, fl[i]);
            wait_ack(6, cyc);
            e = sb.pop_front();
            n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL cond_latency: got %0d expected 2", cyc); end
            n_checks++; if (ack !== e.ack) begin n_fail++; $display("FAIL cond_ack: got %b expected %b", ack, e.ack); end
            n_checks++; if (res_out !== e.res) begin n_fail++; $display("FAIL cond_res: got %h expected %h", res_out, e.res); end
            req[1] = 1'b0;
            tick();
        end
    endtask

    task automatic test_contention();
        exp_t e;
        int   cyc;
        int   c;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        issue(0, OP_SETC, 16'h0000, {8'h00, BR_G}, 4'b0000);
        issue(1, OP_SETC, 16'h0000, {8'h00, BR_G}, 4'b0100);
        for (int t = 0; t < 4; t++) begin
            wait_ack(6, cyc);
            e = sb.pop_front();
            n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL rr_latency%0d: got %0d expected 2", t, cyc); end
            n_checks++; if (ack !== e.ack) begin n_fail++; $display("FAIL rr_ack%0d: got %b expected %b", t, ack, e.ack); end
            n_checks++; if (res_out !== e.res) begin n_fail++; $display("FAIL rr_res%0d: got %h expected %h", t, res_out, e.res); end
            c = e.ack[1] ? 1 : 0;
            req[c] = 1'b0;
            tick();
            if (t < 2) issue(c, OP_ADD, 16'(16'h0101 * (t + 1) + c), 16'h1000, 4'h0);
        end
    endtask

    task automatic test_operand_capture();
        exp_t e;
        int   cyc;
        issue(0, OP_ADD, 16'h1234, 16'h0011, 4'h0);
        tick();
        b_in[15:0] = 16'hFFFF;
        a_in[15:0] = 16'h0000;
        op_in[4:0] = OP_SUB;
        n_checks++; if (alu_b !== 16'h0011) begin n_fail++; $display("FAIL capture_alu_b: got %h expected 0011", alu_b); end
        wait_ack(4, cyc);
        e = sb.pop_front();
        n_checks++; if (ack !== e.ack) begin n_fail++; $display("FAIL capture_ack: got %b expected %b", ack, e.ack); end
        n_checks++; if (res_out !== 16'h1245) begin n_fail++; $display("FAIL capture_res: got %h expected 1245", res_out); end
        req[0] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        int   cyc;
        issue(1, OP_XOR, 16'hAAAA, 16'h0F0F, 4'h0);
        tick();
        n_checks++; if (alu_a !== 16'hAAAA) begin n_fail++; $display("FAIL midrst_granted: got %h expected aaaa", alu_a); end
        reset = 1'b1;
        req   = 2'b00;
        sb.delete();
        tick();
        n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL midrst_ack: got %b expected 00", ack); end
        n_checks++; if ({res_out, alu_a, alu_b} !== 48'h0) begin
            n_fail++; $display("FAIL midrst_clear: got res=%h a=%h b=%h expected 0", res_out, alu_a, alu_b);
        end
        reset = 1'b0;
        tick();
        n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL midrst_noack: got %b expected 00", ack); end
        issue(0, OP_ADD, 16'h0001, 16'hFFFF, 4'h0);
        issue(1, OP_XOR, 16'hAAAA, 16'h0F0F, 4'h0);
        for (int t = 0; t < 2; t++) begin
            wait_ack(6, cyc);
            e = sb.pop_front();
            n_checks++; if (ack !== e.ack) begin n_fail++; $display("FAIL midrst_after_ack%0d: got %b expected %b", t, ack, e.ack); end
            n_checks++; if (res_out !== e.res) begin n_fail++; $display("FAIL midrst_after_res%0d: got %h expected %h", t, res_out, e.res); end
            req[e.ack[1] ? 1 : 0] = 1'b0;
            tick();
        end
    endtask

    task automatic test_random();
        exp_t       e;
        int         cyc;
        int         c;
        logic [4:0] ops[4];
        logic [15:0] b;
        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_XOR; ops[3] = OP_SETC;
        for (int i = 0; i < 8; i++) begin
            c = int'($urandom_range(0, 1));
            b = 16'($urandom);
            if (i % 4 == 3) b = {8'h00, 8'($urandom_range(0, 3))};
            issue(c, ops[i % 4], 16'($urandom), b, 4'($urandom));
            wait_ack(6, cyc);
            e = sb.pop_front();
            n_checks++; if (ack !== e.ack) begin n_fail++; $display("FAIL rand_ack%0d: got %b expected %b", i, ack, e.ack); end
            n_checks++; if (res_out !== e.res) begin n_fail++; $display("FAIL rand_res%0d: got %h expected %h", i, res_out, e.res); end
            req[c] = 1'b0;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_condition();
        test_contention();
        test_operand_capture();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
